reverse_hex_seq: RTL and testbench

REVERSE_HEX_SEQ -- requirements
Module: reverse_hex_seq

---
 rtl/reverse_hex_pkg.sv | 14 +
 rtl/reverse_hex_core.sv | 23 ++
 rtl/reverse_hex_seq.sv | 120 ++++++++++++
 tb/tb_reverse_hex_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reverse_hex_pkg.sv
// Shared definitions for the nibble-reversing sequencer.
//   NibbleW : width of one hex digit
//   state_e : sequencer state encoding (S_IDLE, S_LOAD, S_OUT)
package reverse_hex_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/reverse_hex_core.sv
// Combinational nibble reverse: output nibble i = input nibble N-1-i.
// Nibble i occupies bits [4i:4i+3] of an ascending [0:SIZE-1] word, so
// nibble 0 is the most significant one.
//   word_i : assembled word
//   rev_o  : nibble-reversed word
module reverse_hex_core #(
  parameter int unsigned SIZE = 16
) (
  input  logic [0:SIZE-1] word_i,
  output logic [0:SIZE-1] rev_o
);
  import reverse_hex_pkg::*;

  localparam int unsigned N = SIZE / NibbleW;

  always_comb begin
    rev_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rev_o[i*NibbleW +: NibbleW] = word_i[(N-1-i)*NibbleW +: NibbleW];
    end
  end

endmodule

// File: rtl/reverse_hex_seq.sv
// Collects N = SIZE/4 hex digits (first digit = most significant nibble of
// the assembled word) and presents the nibble-reversed word on dout with a
// valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   din, din_valid        : digit input; din_ready high when a digit is taken
//   flush                 : early commit of a partial word (optional feature)
//   dout, dout_valid      : reversed word, held until dout_ready
//   digit_cnt             : digits accepted in the current word (N in S_OUT)
// Optional feature: define REVERSE_HEX_FLUSH_EN to make flush in S_LOAD commit
// the partial word (missing nibbles are zero). Without it flush is ignored.
module reverse_hex_seq #(
  parameter int unsigned SIZE = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      din,
  input  logic                            din_valid,
  output logic                            din_ready,
  input  logic                            flush,
  output logic [0:SIZE-1]                 dout,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic [$clog2(SIZE/4+1)-1:0]     digit_cnt
);
  import reverse_hex_pkg::*;

  localparam int unsigned N    = SIZE / NibbleW;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(N);

  state_e          state_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [0:SIZE-1] asm_q, asm_d;
  logic [0:SIZE-1] rev;
  logic [0:SIZE-1] dout_q;
  logic            dout_valid_q;
  logic            din_ready_q;
  logic            accept;
  logic            commit;

  // Next assembly word includes the digit accepted this cycle, so a word that
  // completes (or is flushed) on this edge is reversed with that digit in it.
  always_comb begin
    accept = din_valid && din_ready_q;
    asm_d  = asm_q;
    cnt_d  = cnt_q;
    if (accept) begin
      asm_d[int'(cnt_q)*NibbleW +: NibbleW] = din;
      cnt_d = cnt_q + CntW'(1);
    end
    commit = accept && (cnt_d == CntFull);
`ifdef REVERSE_HEX_FLUSH_EN
    if (flush && (state_q == S_LOAD)) begin
      commit = 1'b1;
    end
`endif
  end

`ifndef REVERSE_HEX_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush;
`endif

  reverse_hex_core #(
    .SIZE(SIZE)
  ) u_core (
    .word_i(asm_d),
    .rev_o (rev)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      asm_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_LOAD: begin
          if (commit) begin
            state_q      <= S_OUT;
            cnt_q        <= CntFull;  // saturated while the result is held
            asm_q        <= asm_d;
            dout_q       <= rev;
            dout_valid_q <= 1'b1;
            din_ready_q  <= 1'b0;
          end else if (accept) begin
            state_q <= S_LOAD;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
          end
        end
        S_OUT: begin
          if (dout_ready) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            asm_q        <= '0;
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          asm_q        <= '0;
          dout_valid_q <= 1'b0;
          din_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign din_ready  = din_ready_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_reverse_hex_seq.sv
// Self-checking bench for reverse_hex_seq (SIZE = 16). Directed scenarios plus
// a randomized run checked against a digit-list reference model.
module tb_reverse_hex_seq;

  localparam int unsigned SIZE = 16;
  localparam int unsigned N    = SIZE / 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      din;
  logic            din_valid;
  logic            din_ready;
  logic            flush;
  logic [0:SIZE-1] dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [2:0]      digit_cnt;

  int checks = 0;
  int errors = 0;

  reverse_hex_seq #(
    .SIZE(SIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .flush     (flush),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    din_valid  = 1'b0;
    din        = 4'h0;
    flush      = 1'b0;
    dout_ready = 1'b0;
  endtask

  // Digits list -> expected reversed word: digit k lands in nibble weight 16^k.
  function automatic logic [SIZE-1:0] expect_word(input logic [3:0] d[$]);
    logic [SIZE-1:0] w = '0;
    for (int k = 0; k < d.size(); k++) w = w | (SIZE'(d[k]) << (4 * k));
    return w;
  endfunction

  task automatic send_digit(input logic [3:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (digit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", digit_cnt); end
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
    checks++;
    if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", din_ready); end
    checks++;
    if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout got %h want 0000", dout); end
  endtask

  task automatic test_basic();
    logic [3:0] d[4] = '{4'ha, 4'hb, 4'hc, 4'hd};
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_digit(d[i]);
      if (i == 2) begin
        checks++;
        if (dout_valid !== 1'b0 || digit_cnt !== 3'd3) begin
          errors++;
          $display("FAIL basic_partial got valid=%b cnt=%0d want valid=0 cnt=3", dout_valid, digit_cnt);
        end
      end
    end
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'hdcba) begin
      errors++;
      $display("FAIL basic_out got valid=%b dout=%h want valid=1 dout=dcba", dout_valid, dout);
    end
    checks++;
    if (din_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_out got %b want 0", din_ready); end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL basic_after got valid=%b ready=%b cnt=%0d want 0 1 0", dout_valid, din_ready, digit_cnt);
    end
    checks++;
    if (dout !== 16'hdcba) begin errors++; $display("FAIL basic_retain got %h want dcba", dout); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [3:0] d[4] = '{4'ha, 4'hc, 4'he, 4'hf};
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_digit(d[i]);
    for (int c = 0; c < 5; c++) begin
      din = 4'($urandom_range(0, 15));
      din_valid = 1'b1;
      checks++;
      if (dout_valid !== 1'b1 || dout !== 16'hfeca || din_ready !== 1'b0 || digit_cnt !== 3'd4) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid=%b dout=%h ready=%b cnt=%0d want 1 feca 0 4",
                 c, dout_valid, dout, din_ready, digit_cnt);
      end
      tick();
    end
    din_valid = 1'b0;
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL bp_release got valid=%b ready=%b cnt=%0d want 0 1 0", dout_valid, din_ready, digit_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midload();
    send_digit(4'h7);
    send_digit(4'h9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (digit_cnt !== 3'd0 || dout_valid !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got cnt=%0d valid=%b ready=%b want 0 0 1", digit_cnt, dout_valid, din_ready);
    end
    for (int i = 1; i <= 4; i++) send_digit(4'(i));
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h4321) begin
      errors++;
      $display("FAIL rst_word got valid=%b dout=%h want 1 4321", dout_valid, dout);
    end
    // Reset while a result is held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 16'h0000 || din_ready !== 1'b1 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rst_out got valid=%b dout=%h ready=%b cnt=%0d want 0 0000 1 0",
               dout_valid, dout, din_ready, digit_cnt);
    end
    idle_inputs();
  endtask

`ifdef REVERSE_HEX_FLUSH_EN
  task automatic test_flush();
    flush = 1'b1;
    tick();
    tick();
    flush = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || digit_cnt !== 3'd0) begin
      errors++;
      $display("FAIL flush_idle got valid=%b cnt=%0d want 0 0", dout_valid, digit_cnt);
    end
    send_digit(4'ha);
    send_digit(4'hc);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h00ca || digit_cnt !== 3'd4) begin
      errors++;
      $display("FAIL flush_partial got valid=%b dout=%h cnt=%0d want 1 00ca 4", dout_valid, dout, digit_cnt);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    send_digit(4'ha);
    send_digit(4'hb);
    flush = 1'b1;
    send_digit(4'hc);
    flush = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'h0cba) begin
      errors++;
      $display("FAIL flush_with_digit got valid=%b dout=%h want 1 0cba", dout_valid, dout);
    end
    dout_ready = 1'b1;
    tick();
    idle_inputs();
  endtask
`else
  task automatic test_flush();
    send_digit(4'ha);
    send_digit(4'hc);
    flush = 1'b1;
    tick();
    tick();
    checks++;
    if (dout_valid !== 1'b0 || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL noflush_hold got valid=%b cnt=%0d want 0 2", dout_valid, digit_cnt);
    end
    send_digit(4'hb);
    checks++;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL noflush_3rd got valid=%b want 0", dout_valid); end
    send_digit(4'hd);
    flush = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'hdbca) begin
      errors++;
      $display("FAIL noflush_word got valid=%b dout=%h want 1 dbca", dout_valid, dout);
    end
    dout_ready = 1'b1;
    tick();
    idle_inputs();
  endtask
`endif

  // Randomized traffic against a digit-list model of the block.
  task automatic test_random();
    logic [3:0]      digits[$];
    logic            m_valid = 1'b0;
    logic [SIZE-1:0] m_out = '0;
    int              words = 0;
    bit              flush_en;
`ifdef REVERSE_HEX_FLUSH_EN
    flush_en = 1'b1;
`else
    flush_en = 1'b0;
`endif
    m_out = SIZE'(dout);  // last held value carries over from earlier tests
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (din_ready !== !m_valid || dout_valid !== m_valid ||
          digit_cnt !== (m_valid ? 3'(N) : 3'(digits.size())) || dout !== m_out) begin
        errors++;
        $display("FAIL rand cycle %0d got ready=%b valid=%b cnt=%0d dout=%h want %b %b %0d %h",
                 cyc, din_ready, dout_valid, digit_cnt, dout, !m_valid, m_valid,
                 m_valid ? N : digits.size(), m_out);
      end
      din_valid  = ($urandom_range(0, 9) < 7);
      din        = 4'($urandom_range(0, 15));
      dout_ready = $urandom_range(0, 1) == 1;
      flush      = ($urandom_range(0, 7) == 0);
      if (m_valid) begin
        if (dout_ready) begin
          m_valid = 1'b0;
          digits.delete();
        end
      end else begin
        bit loading = digits.size() > 0;
        if (din_valid) digits.push_back(din);
        if (digits.size() == N || (flush_en && flush && loading)) begin
          m_valid = 1'b1;
          m_out   = expect_word(digits);
          words++;
        end
      end
      tick();
    end
    checks++;
    if (words < 20) begin errors++; $display("FAIL rand_words got %0d want >=20", words); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_midload();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
